// File: rtl/pill_sense.sv
// Pill-drop photo-sensor conditioner: 2-flop synchroniser, debounce FSM, one isWork
// pulse per pill, BCD pill count and optional jam detection (enabled by PILL_JAM_EN).
module pill_sense #(
  parameter int DEB_CYC = 4,
  parameter int JAM_CYC = 200,
  parameter int GAP_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_work,
  input  logic       sensor_raw,
  input  logic       clr_jam,
  output logic       isWork,
  output logic       busy,
  output logic       jam,
  output logic [3:0] cntL,
  output logic [3:0] cntH,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_HIGH = 3'd2,
    ST_FALL = 3'd3,
    ST_GAP  = 3'd4
`ifdef PILL_JAM_EN
    , ST_JAM = 3'd5
`endif
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC);

  // Handshake-free block: isWork is a plain one-cycle strobe, no ready back-pressure.
  logic       r_sync1;
  logic       r_s;
  state_t     r_state;
  logic [3:0] r_deb;
  logic [3:0] r_gcnt;
  logic       r_is_work;
  logic       r_busy;
  logic [3:0] r_cnt_l;
  logic [3:0] r_cnt_h;

  state_t     w_state_nxt;
  logic [3:0] w_deb_nxt;
  logic [3:0] w_gcnt_nxt;
  logic       w_accept;

`ifdef PILL_JAM_EN
  localparam logic [7:0] JAM_LAST = 8'(JAM_CYC - 1);
  logic [7:0] r_jcnt;
  logic [7:0] w_jcnt_nxt;
  logic [7:0] w_jcnt_inc;
  logic       w_jam_hit;
  logic       r_jam;

  // Saturate so a long hold can never wrap back under the jam threshold.
  assign w_jcnt_inc = (r_jcnt == 8'hFF) ? r_jcnt : r_jcnt + 8'd1;
  assign w_jam_hit  = (r_jcnt >= JAM_LAST);
`else
  logic w_unused_clr_jam;
  assign w_unused_clr_jam = clr_jam;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_gcnt_nxt  = r_gcnt;
    w_accept    = 1'b0;
`ifdef PILL_JAM_EN
    w_jcnt_nxt  = r_jcnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (EN_work && r_s) begin
          w_state_nxt = ST_RISE;
          w_deb_nxt   = 4'd1;
        end
      end
      ST_RISE: begin
        if (!EN_work || !r_s) begin
          w_state_nxt = ST_IDLE;
          w_deb_nxt   = 4'd0;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = ST_HIGH;
          w_deb_nxt   = 4'd0;
          w_accept    = 1'b1;
`ifdef PILL_JAM_EN
          w_jcnt_nxt  = 8'd0;
`endif
        end else begin
          w_deb_nxt = r_deb + 4'd1;
        end
      end
      ST_HIGH: begin
`ifdef PILL_JAM_EN
        w_jcnt_nxt = w_jcnt_inc;
`endif
        if (!r_s) begin
          w_state_nxt = ST_FALL;
          w_deb_nxt   = 4'd1;
`ifdef PILL_JAM_EN
        end else if (w_jam_hit) begin
          w_state_nxt = ST_JAM;
`endif
        end
      end
      ST_FALL: begin
`ifdef PILL_JAM_EN
        w_jcnt_nxt = w_jcnt_inc;
`endif
        // A completed release debounce wins over a jam on the same edge.
        if (!r_s && (r_deb == DEB_LAST)) begin
          w_state_nxt = ST_GAP;
          w_deb_nxt   = 4'd0;
          w_gcnt_nxt  = 4'd0;
`ifdef PILL_JAM_EN
        end else if (w_jam_hit) begin
          w_state_nxt = ST_JAM;
          w_deb_nxt   = 4'd0;
`endif
        end else if (r_s) begin
          w_state_nxt = ST_HIGH;
          w_deb_nxt   = 4'd0;
        end else begin
          w_deb_nxt = r_deb + 4'd1;
        end
      end
      ST_GAP: begin
        if (r_gcnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_gcnt_nxt  = 4'd0;
        end else begin
          w_gcnt_nxt = r_gcnt + 4'd1;
        end
      end
`ifdef PILL_JAM_EN
      ST_JAM: begin
        if (clr_jam && !r_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_deb_nxt   = 4'd0;
        w_gcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= 1'b0;
      r_s       <= 1'b0;
      r_state   <= ST_IDLE;
      r_deb     <= 4'd0;
      r_gcnt    <= 4'd0;
      r_is_work <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt_l   <= 4'd0;
      r_cnt_h   <= 4'd0;
    end else begin
      r_sync1   <= sensor_raw;
      r_s       <= r_sync1;
      r_state   <= w_state_nxt;
      r_deb     <= w_deb_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_is_work <= w_accept;
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        if (r_cnt_l == 4'd9) begin
          r_cnt_l <= 4'd0;
          r_cnt_h <= (r_cnt_h == 4'd9) ? 4'd0 : r_cnt_h + 4'd1;
        end else begin
          r_cnt_l <= r_cnt_l + 4'd1;
        end
      end
    end
  end

`ifdef PILL_JAM_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_jcnt <= 8'd0;
      r_jam  <= 1'b0;
    end else begin
      r_jcnt <= w_jcnt_nxt;
      r_jam  <= (w_state_nxt == ST_JAM);
    end
  end
  assign jam = r_jam;
`else
  assign jam = 1'b0;
`endif

  assign isWork      = r_is_work;
  assign busy        = r_busy;
  assign cntL        = r_cnt_l;
  assign cntH        = r_cnt_h;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pill_sense.sv
// Bench for pill_sense: directed scenarios plus random sensor traffic, every cycle
// compared against a run-length model of the pill acceptance rules.
module tb_pill_sense;

  localparam int DEB = 4;
  localparam int JAM = 200;
  localparam int GAP = 2;
`ifdef PILL_JAM_EN
  localparam bit JAM_ON = 1'b1;
`else
  localparam bit JAM_ON = 1'b0;
`endif

  // model modes: waiting/qualifying, pill held, dead gap, jammed
  localparam int M_WAIT = 0;
  localparam int M_HOLD = 1;
  localparam int M_GAP  = 2;
  localparam int M_JAM  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN_work;
  logic       sensor_raw;
  logic       clr_jam;
  logic       isWork;
  logic       busy;
  logic       jam;
  logic [3:0] cntL;
  logic [3:0] cntH;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int cyc = 0;
  int last_pulse_cyc = -1;

  logic [10:0] exp_q[$];

  int m_q[$];
  int m_mode, m_run, m_t, m_low, m_gap, m_cnt;
  bit m_pulse;

  pill_sense #(.DEB_CYC(DEB), .JAM_CYC(JAM), .GAP_CYC(GAP)) dut (
    .CLK(CLK), .RST(RST), .EN_work(EN_work), .sensor_raw(sensor_raw),
    .clr_jam(clr_jam), .isWork(isWork), .busy(busy), .jam(jam),
    .cntL(cntL), .cntH(cntH), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pill is accepted after DEB consecutive enabled high samples, released after
  // DEB consecutive lows, followed by GAP+1 ignored edges; jam after JAM edges held.
  task automatic model_edge(input logic raw, input logic en, input logic clr, input logic rst);
    int s;
    m_pulse = 1'b0;
    if (rst) begin
      m_q = '{0, 0};
      m_mode = M_WAIT; m_run = 0; m_t = 0; m_low = 0; m_gap = 0; m_cnt = 0;
      return;
    end
    s = m_q.pop_front();
    m_q.push_back(raw ? 1 : 0);
    case (m_mode)
      M_WAIT: begin
        if (en === 1'b1 && s == 1) begin
          m_run++;
          if (m_run == DEB) begin
            m_pulse = 1'b1;
            m_cnt = (m_cnt + 1) % 100;
            m_mode = M_HOLD; m_t = 0; m_low = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      M_HOLD: begin
        m_t++;
        if (s == 0 && m_low + 1 >= DEB) begin
          m_mode = M_GAP; m_gap = GAP + 1;
        end else if (JAM_ON && m_t >= JAM && !(s == 0 && m_low == 0)) begin
          m_mode = M_JAM;
        end else begin
          m_low = (s == 1) ? 0 : m_low + 1;
        end
      end
      M_GAP: begin
        m_gap--;
        if (m_gap == 0) m_mode = M_WAIT;
      end
      default: begin
        if (clr === 1'b1 && s == 0) m_mode = M_WAIT;
      end
    endcase
  endtask

  function automatic logic [10:0] model_vec();
    logic busy_e;
    busy_e = (m_mode != M_WAIT) || (m_run > 0);
    return {m_pulse, busy_e, (m_mode == M_JAM), 4'(m_cnt / 10), 4'(m_cnt % 10)};
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic raw, input logic en, input logic clr);
    logic [10:0] exp;
    sensor_raw = raw; EN_work = en; clr_jam = clr;
    @(posedge CLK);
    model_edge(raw, en, clr, RST);
    exp_q.push_back(model_vec());
    #1;
    exp = exp_q.pop_front();
    check("outputs", {5'd0, isWork, busy, jam, cntH, cntL}, {5'd0, exp});
    if (isWork === 1'b1) begin
      n_pulse++;
      last_pulse_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, p0, len;
    bit lvl, en_r, clr_r;

    RST = 1'b1; EN_work = 1'b0; sensor_raw = 1'b0; clr_jam = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("reset_outs", {5'd0, isWork, busy, jam, cntH, cntL}, 16'd0);
    RST = 1'b0;
    hold(1'b0, 4);

    // clean pill
    base = cyc; p0 = n_pulse;
    hold(1'b1, 10);
    check("clean_edge", 16'(last_pulse_cyc - base), 16'(DEB + 1));
    hold(1'b0, 15);
    check("clean_pulses", 16'(n_pulse - p0), 16'd1);
    check("clean_cnt", {8'd0, cntH, cntL}, 16'h0001);
    check("clean_busy", {15'd0, busy}, 16'd0);

    // glitch shorter than debounce
    p0 = n_pulse;
    hold(1'b1, 2);
    hold(1'b0, 10);
    check("glitch_pulses", 16'(n_pulse - p0), 16'd0);
    check("glitch_cnt", {8'd0, cntH, cntL}, 16'h0001);
    check("glitch_busy", {15'd0, busy}, 16'd0);

    // bounce on release
    p0 = n_pulse;
    hold(1'b1, 8);
    for (int i = 0; i < 6; i++) step(i[0] ? 1'b1 : 1'b0, 1'b1, 1'b0);
    hold(1'b0, 15);
    check("bounce_pulses", 16'(n_pulse - p0), 16'd1);
    check("bounce_cnt", {8'd0, cntH, cntL}, 16'h0002);

    // enable low while blocked
    p0 = n_pulse;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check("en_off_pulses", 16'(n_pulse - p0), 16'd0);

    // reset while in RISE
    p0 = n_pulse;
    hold(1'b1, 4);
    RST = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    RST = 1'b0;
    hold(1'b0, 10);
    check("rst_rise_pulses", 16'(n_pulse - p0), 16'd0);
    check("rst_rise_outs", {5'd0, isWork, busy, jam, cntH, cntL}, 16'd0);

    // BCD wrap over 100 pills
    p0 = n_pulse;
    for (int k = 0; k < 99; k++) begin
      hold(1'b1, 8);
      hold(1'b0, 12);
    end
    check("wrap_99", {8'd0, cntH, cntL}, 16'h0099);
    hold(1'b1, 8);
    hold(1'b0, 12);
    check("wrap_00", {8'd0, cntH, cntL}, 16'h0000);
    check("wrap_pulses", 16'(n_pulse - p0), 16'd100);

    // long hold: jam when built, otherwise nothing
    do_reset();
    hold(1'b1, 250);
    check("jam_hold", {15'd0, jam}, {15'd0, JAM_ON});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check("jam_clr_blocked", {15'd0, jam}, {15'd0, JAM_ON});
    hold(1'b0, 8);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 4);
    check("jam_cleared", {15'd0, jam}, 16'd0);
    check("jam_busy", {15'd0, busy}, 16'd0);
    check("jam_cnt", {8'd0, cntH, cntL}, 16'h0001);

    // random traffic
    do_reset();
    lvl = 1'b0;
    for (int k = 0; k < 80; k++) begin
      len   = $urandom_range(1, 12);
      en_r  = ($urandom_range(0, 7) != 0);
      clr_r = $urandom_range(0, 1);
      lvl   = ~lvl;
      for (int j = 0; j < len; j++) step(lvl, en_r, clr_r);
    end
    hold(1'b0, 20);
    check("rand_busy_end", {15'd0, busy}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
